// File: rtl/airi5c_dmem_ctrl_if.sv
// ============================================================================
//  Module   : airi5c_dmem_ctrl_if
//  Brief    : Data-bus signal bundle between the LSU controller and memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface airi5c_dmem_ctrl_if;
    logic [31:0] bus_addr;
    logic        bus_en;
    logic        bus_wen;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_error;

    modport master (
        output bus_addr, bus_en, bus_wen, bus_be, bus_wdata,
        input  bus_rdata, bus_ready, bus_error
    );

    modport slave (
        input  bus_addr, bus_en, bus_wen, bus_be, bus_wdata,
        output bus_rdata, bus_ready, bus_error
    );
endinterface

`default_nettype wire

// File: rtl/airi5c_dmem_ctrl.sv
// ============================================================================
//  Module   : airi5c_dmem_ctrl
//  Brief    : Load/store bus controller: alignment, lane steering, extension.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module airi5c_dmem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  wire logic        clk,
    input  wire logic        nreset,
    input  wire logic [31:0] dmem_addr,
    input  wire logic        loadstore_EX,
    input  wire logic        store_EX,
    input  wire logic [1:0]  size_EX,
    input  wire logic        unsigned_EX,
    input  wire logic [31:0] store_data_EX,
    input  wire logic        flush,
    airi5c_dmem_ctrl_if.master bus,
    output logic             stall_lsu,
    output logic [31:0]      load_data,
    output logic             load_valid,
    output logic             misaligned_ld,
    output logic             misaligned_st,
    output logic             access_fault
);

    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    typedef enum logic [0:0] {IDLE = 1'b0, DATA = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        kill_q, kill_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        access_fault_q, access_fault_d;

    logic        aligned, issue, in_data, timeout, killed;
    logic [3:0]  be;
    logic [31:0] wsteer, shifted, ext;

    always_comb begin
        aligned = 1'b1;
        be      = 4'b1111;
        wsteer  = store_data_EX;
        unique case (size_EX)
            2'b00: begin
                aligned = 1'b1;
                be      = 4'b0001 << dmem_addr[1:0];
                wsteer  = {4{store_data_EX[7:0]}};
            end
            2'b01: begin
                aligned = ~dmem_addr[0];
                be      = dmem_addr[1] ? 4'b1100 : 4'b0011;
                wsteer  = {2{store_data_EX[15:0]}};
            end
            default: begin
                aligned = (dmem_addr[1:0] == 2'b00);
                be      = 4'b1111;
                wsteer  = store_data_EX;
            end
        endcase
    end

    always_comb begin
        shifted = bus.bus_rdata >> {off_q, 3'b000};
        unique case (size_q)
            2'b00:   ext = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ext = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    // A new access may overlap the data phase only in the cycle it completes.
    assign in_data = (state_q == DATA);
    assign issue   = loadstore_EX & ~flush & aligned & (~in_data | bus.bus_ready);
    assign timeout = in_data & ~bus.bus_ready & (cnt_q == TIMEOUT_C);
    assign killed  = kill_q | flush;

    assign stall_lsu     = in_data & ~bus.bus_ready & ~timeout;
    assign misaligned_ld = loadstore_EX & ~flush & ~aligned & ~stall_lsu & ~store_EX;
    assign misaligned_st = loadstore_EX & ~flush & ~aligned & ~stall_lsu &  store_EX;

    assign bus.bus_en    = issue;
    assign bus.bus_wen   = issue & store_EX;
    assign bus.bus_be    = issue ? be : 4'b0000;
    assign bus.bus_addr  = issue ? {dmem_addr[31:2], 2'b00} : 32'b0;
    assign bus.bus_wdata = in_data ? wdata_q : 32'b0;

    assign load_data    = load_data_q;
    assign load_valid   = load_valid_q;
    assign access_fault = access_fault_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        kill_d         = kill_q;
        store_d        = store_q;
        size_d         = size_q;
        uns_d          = uns_q;
        off_d          = off_q;
        wdata_d        = wdata_q;
        load_data_d    = load_data_q;
        load_valid_d   = 1'b0;
        access_fault_d = 1'b0;

        if (in_data) begin
            if (bus.bus_ready) begin
                if (bus.bus_error) begin
                    access_fault_d = ~killed;
                end else if (~store_q) begin
                    load_data_d  = ext;
                    load_valid_d = ~killed;
                end
                state_d = IDLE;
                kill_d  = 1'b0;
                cnt_d   = 8'd0;
            end else if (timeout) begin
                access_fault_d = ~killed;
                state_d        = IDLE;
                kill_d         = 1'b0;
                cnt_d          = 8'd0;
            end else begin
                kill_d = killed;
                cnt_d  = cnt_q + 8'd1;
            end
        end

        if (issue) begin
            state_d = DATA;
            cnt_d   = 8'd0;
            kill_d  = 1'b0;
            store_d = store_EX;
            size_d  = size_EX;
            uns_d   = unsigned_EX;
            off_d   = dmem_addr[1:0];
            wdata_d = store_EX ? wsteer : 32'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            kill_q         <= 1'b0;
            store_q        <= 1'b0;
            size_q         <= 2'b00;
            uns_q          <= 1'b0;
            off_q          <= 2'b00;
            wdata_q        <= 32'b0;
            load_data_q    <= 32'b0;
            load_valid_q   <= 1'b0;
            access_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            kill_q         <= kill_d;
            store_q        <= store_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            off_q          <= off_d;
            wdata_q        <= wdata_d;
            load_data_q    <= load_data_d;
            load_valid_q   <= load_valid_d;
            access_fault_q <= access_fault_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/airi5c_dmem_ctrl.md
# airi5c_dmem_ctrl

Data-memory access controller directly downstream of the EX-stage address latch. Takes the load/store address (`dmem_addr`) and the operation info from EX, checks alignment, runs the address-phase/data-phase handshake on the data bus, and steers store lanes and byte enables. It also extracts and sign/zero-extends load data and reports stall, misalignment and bus-error events to the pipeline.

## Interface
Parameters:
- `TIMEOUT`, default 255: max data-phase wait cycles before a bus timeout error; range 1..255; 8-bit counter.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `nreset`  in  1  reset, asynchronous, active-low.
- `dmem_addr`  in  `XPR_LEN` (32)  effective address from the EX address latch.
- `loadstore_EX`  in  1  valid load/store in EX this cycle.
- `store_EX`  in  1  1 = store, 0 = load; qualified by `loadstore_EX`.
- `size_EX`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `unsigned_EX`  in  1  load zero-extends when 1.
- `store_data_EX`  in  32  rs2 value.
- `flush`  in  1  kill the instruction in EX and suppress an outstanding load writeback.
- `bus_addr`  out  32  bus address; word-aligned (`dmem_addr[31:2]`,2'b00).
- `bus_en`  out  1  address-phase request.
- `bus_wen`  out  1  write request.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  steered store data, driven in data phase.
- `bus_rdata`  in  32  read data, valid with `bus_ready`.
- `bus_ready`  in  1  data phase complete.
- `bus_error`  in  1  slave error, sampled with `bus_ready`.
- `stall_lsu`  out  1  hold pipeline.
- `load_data`  out  32  extended load result.
- `load_valid`  out  1  one-cycle pulse, `load_data` valid.
- `misaligned_ld`  out  1  one-cycle pulse.
- `misaligned_st`  out  1  one-cycle pulse.
- `access_fault`  out  1  one-cycle pulse on slave error or timeout.

## Operation
- States: IDLE, DATA.
- **Issue condition:** `loadstore_EX & ~flush & aligned & (state==IDLE | (state==DATA & bus_ready))`.
  - On issue: `bus_en`=1 combinationally, `bus_wen`=`store_EX`, `bus_be` from size and `addr[1:0]`.
  - Registered on issue: `store_EX`, size, unsigned, `addr[1:0]`, steered wdata.
  - Next state is DATA.
- **Alignment:** byte always aligned; half requires `addr[0]`=0; word requires `addr[1:0]`=0.
  - A misaligned request pulses `misaligned_ld` or `misaligned_st` in the same cycle (combinational).
  - No bus access is made for it; the state machine is unaffected.
- **Byte enables:** byte: 1<<`addr[1:0]`; half: 4'b0011 or 4'b1100 by `addr[1]`; word: 4'b1111.
- **Store steering:** byte replicated to 4 lanes; half replicated to 2 lanes; word unchanged. `bus_wdata` is driven from the register during DATA, otherwise 0.
- **Load extraction:** shift `bus_rdata` right by 8×registered `addr[1:0]`, mask to size, then sign- or zero-extend.
- **DATA state:**
  - `bus_ready` & ~`bus_error`: a load registers `load_data`, and `load_valid` pulses in the next cycle unless flush was seen while outstanding. A store just completes.
  - `bus_ready` & `bus_error`: `access_fault` pulses in the next cycle; no `load_valid`.
  - Next state is DATA if a new issue happened in the same cycle, else IDLE.
- **Timeout:** the counter clears on entering DATA and increments each DATA cycle without ready. Reaching `TIMEOUT` pulses `access_fault` next cycle and forces IDLE. A late `bus_ready` arriving in IDLE is ignored.
- **Stall:** `stall_lsu` = `state==DATA & ~bus_ready`, deasserted in the timeout cycle.
- **Flush:**
  - In IDLE it blocks issue.
  - In DATA the bus transaction still completes; a sticky kill bit suppresses `load_valid`/`access_fault`.
  - The kill bit clears when the transaction ends.

## Timing
- **Reset:** state IDLE; counter 0; kill 0; all registered outputs 0 (`load_data`, `load_valid`, `access_fault`, registered wdata/be/size). Combinational outputs are 0 while `loadstore_EX`=0.
- Address phase is cycle T; data phase starts at T+1.
- Zero-wait load: `bus_ready` at T+1, so `load_valid`/`load_data` appear at T+2.
- Back-to-back: a new address phase may overlap a completing data phase; sustained throughput is 1 access/cycle.
- Reset asserted mid-transaction returns to IDLE immediately. No pulse is emitted and no bus response is awaited.
- `bus_ready` and a new misaligned request in the same cycle: the completion is processed, the misalign pulse is emitted, and the next state is IDLE.

## Test plan
- Word load at 0x1000, rdata 0xDEADBEEF, ready at T+1 → `bus_be`=1111; `load_valid` at T+2 with `load_data`=0xDEADBEEF; `stall_lsu` never 1.
- Signed byte load at 0x1003, rdata 0x80FF_0000 → `load_data`=0xFFFFFF80. Unsigned half load at 0x1002 → `load_data`=0x000080FF.
- Byte store of 0x12345678 at 0x2001 → `bus_be`=0010, `bus_wdata`=0x78787878 at T+1. Half store at 0x2002 → `bus_be`=1100, `bus_wdata`=0x56785678.
- Half load at 0x3001 → `misaligned_ld` pulse, `bus_en`=0, no `load_valid`. Word store at 0x3002 → `misaligned_st` pulse.
- Load with `bus_ready` delayed 3 cycles → `stall_lsu`=1 for 3 cycles. With `flush` asserted in wait cycle 2 → no `load_valid`. Load with `bus_error`=1 on ready → `access_fault` pulse, no `load_valid`.
- `TIMEOUT`=4, ready never asserted → `stall_lsu` high 4 cycles, `access_fault` pulse, then IDLE. A subsequent word load completes normally.
